// File: rtl/or_gate_xor.sv
// Bitwise OR built from XOR/AND, with a registered copy, a valid flag and a
// saturating count of cycles on which the OR result was nonzero.
`default_nettype none

module or_gate_xor #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             y_vld,
   output logic [CNT_W-1:0] act_cnt,
   output logic             act_sat
);

   // a|b == (a^b)^(a&b): the XOR term covers 01/10, the AND term covers 11,
   // and the two are never both set, so the outer XOR acts as the OR.
   assign y       = (a ^ b) ^ (a & b);
   assign act_sat = &act_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the reset here is synchronous, so rst is only
   // examined on the rising edge and is not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         y_vld   <= 1'b0;
         act_cnt <= '0;
      end else begin
         y_q   <= y;
         y_vld <= 1'b1;
         if ((|y) && !act_sat)
            act_cnt <= act_cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_or_gate_xor.sv
// Directed and random checks of or_gate_xor across several parameterisations
// sharing one clock.
`timescale 1ns/1ps

module tb_or_gate_xor;

   logic clk = 1'b0;
   logic run = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   // WIDTH=1 instance for the truth table
   logic       a1 = 1'b0, b1 = 1'b0;
   logic       y1, yq1, vld1, sat1;
   logic [15:0] cnt1;

   // WIDTH=4 instance for the bitwise vector
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] y4, yq4;
   logic       vld4, sat4;
   logic [15:0] cnt4;

   // WIDTH=8 instance for counter, mid-run reset and random stimulus
   logic [7:0] a8 = '0, b8 = '0;
   logic [7:0] y8, yq8;
   logic       vld8, sat8;
   logic [15:0] cnt8;

   // CNT_W=2 instance for saturation
   logic       as = 1'b0, bs = 1'b0;
   logic       ys, yqs, vlds, sats;
   logic [1:0] cnts;

   or_gate_xor #(.WIDTH(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1),
      .y_vld(vld1), .act_cnt(cnt1), .act_sat(sat1));

   or_gate_xor #(.WIDTH(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4),
      .y_vld(vld4), .act_cnt(cnt4), .act_sat(sat4));

   or_gate_xor #(.WIDTH(8), .CNT_W(16)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .y_q(yq8),
      .y_vld(vld8), .act_cnt(cnt8), .act_sat(sat8));

   or_gate_xor #(.WIDTH(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .a(as), .b(bs), .y(ys), .y_q(yqs),
      .y_vld(vlds), .act_cnt(cnts), .act_sat(sats));

   // Clock only toggles while run is set, so it can be parked low.
   always begin
      #5;
      if (run) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0]  ra, rb, prev;
      logic [15:0] exp_cnt;
      logic [1:0]  tt_a [4];
      logic        tt_y [4];
      tt_a = '{2'b00, 2'b01, 2'b10, 2'b11};
      tt_y = '{1'b0, 1'b1, 1'b1, 1'b1};

      // Truth table with the clock parked low and rst high
      for (int i = 0; i < 4; i++) begin
         a1 = tt_a[i][1];
         b1 = tt_a[i][0];
         #10;
         check($sformatf("truth_table_%0d", i), 32'(y1), 32'(tt_y[i]));
      end
      check("clk_idle", 32'(clk), 32'd0);

      // First reset edge
      run = 1'b1;
      do_reset();
      check("rst_yq8",  32'(yq8),  32'd0);
      check("rst_vld8", 32'(vld8), 32'd0);
      check("rst_cnt8", 32'(cnt8), 32'd0);
      check("rst_sat8", 32'(sat8), 32'd0);
      check("rst_cnts", 32'(cnts), 32'd0);
      check("rst_sats", 32'(sats), 32'd0);
      check("rst_vld4", 32'(vld4), 32'd0);

      // 4-bit vector: combinational now, registered after one edge
      a4 = 4'b1010;
      b4 = 4'b0110;
      #1;
      check("w4_y_now", 32'(y4), 32'h0000000e);
      check("w4_yq_before", 32'(yq4), 32'd0);
      tick();
      check("w4_yq", 32'(yq4), 32'h0000000e);
      check("w4_vld", 32'(vld4), 32'd1);

      // Counter: 5 active edges then 3 idle edges
      do_reset();
      a8 = 8'h01; b8 = 8'h00;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("cnt_up_%0d", i), 32'(cnt8), 32'(i));
      end
      a8 = 8'h00;
      for (int i = 0; i < 3; i++) tick();
      check("cnt_hold", 32'(cnt8), 32'd5);
      check("cnt_sat",  32'(sat8), 32'd0);
      check("cnt_yq0",  32'(yq8),  32'd0);
      check("cnt_vld",  32'(vld8), 32'd1);

      // Saturation with a 2-bit counter
      do_reset();
      as = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("sat_cnt_%0d", i), 32'(cnts), 32'((i >= 3) ? 3 : i));
         check($sformatf("sat_flag_%0d", i), 32'(sats), 32'((i >= 3) ? 1 : 0));
      end
      as = 1'b0;

      // Reset mid-operation with a held at 1
      do_reset();
      a8 = 8'h01;
      for (int i = 0; i < 4; i++) tick();
      check("mid_pre_cnt", 32'(cnt8), 32'd4);
      check("mid_pre_yq",  32'(yq8),  32'd1);
      rst = 1'b1;
      #1;
      check("mid_y_in_rst", 32'(y8), 32'd1);
      tick();
      check("mid_yq",  32'(yq8),  32'd0);
      check("mid_vld", 32'(vld8), 32'd0);
      check("mid_cnt", 32'(cnt8), 32'd0);
      check("mid_sat", 32'(sat8), 32'd0);
      check("mid_y",   32'(y8),   32'd1);
      rst = 1'b0;

      // Glitch between edges must not be captured
      a8 = 8'h00;
      tick();
      a8 = 8'hff;
      #2;
      check("glitch_y", 32'(y8), 32'h000000ff);
      a8 = 8'h00;
      tick();
      check("glitch_yq",  32'(yq8),  32'd0);
      check("glitch_cnt", 32'(cnt8), 32'd0);

      // Random stimulus against a reference model
      do_reset();
      prev    = '0;
      exp_cnt = '0;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 7 == 0) begin
            ra = '0;
            rb = '0;
         end
         a8 = ra;
         b8 = rb;
         #1;
         check("rnd_y", 32'(y8), 32'(ra | rb));
         tick();
         prev = ra | rb;
         if (prev != 0 && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
         check("rnd_yq",  32'(yq8),  32'(prev));
         check("rnd_cnt", 32'(cnt8), 32'(exp_cnt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
